// File: rtl/nios_mult_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nios_mult_pkg : op codes and signedness decode for nios_mult_pipe  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package nios_mult_pkg;

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULXUU = 2'b01;
   localparam logic [1:0] OP_MULXSU = 2'b10;
   localparam logic [1:0] OP_MULXSS = 2'b11;

   function automatic logic op_is_high(input logic [1:0] op);
      return op != OP_MUL;
   endfunction

   function automatic logic op_a_signed(input logic [1:0] op);
      return (op == OP_MULXSU) || (op == OP_MULXSS);
   endfunction

   function automatic logic op_b_signed(input logic [1:0] op);
      return op == OP_MULXSS;
   endfunction

endpackage
`default_nettype wire

// File: rtl/nios_mult_pp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nios_mult_pp : registered HxH unsigned multiplier with load enable |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module nios_mult_pp #(
   parameter int H = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           en,
   input  logic [H-1:0]   a,
   input  logic [H-1:0]   b,
   output logic [2*H-1:0] p
);

   logic [2*H-1:0] p_q, p_d;

   always_comb begin
      p_d = p_q;
      if (en) begin
         p_d = {{H{1'b0}}, a} * {{H{1'b0}}, b};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p_q <= '0;
      end else begin
         p_q <= p_d;
      end
   end

   assign p = p_q;

endmodule
`default_nettype wire

// File: rtl/nios_mult_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nios_mult_pipe : 3-stage WxW multiplier, signed/unsigned ops,      |
// |                  valid/ready handshake and sideband tag            |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module nios_mult_pipe
   import nios_mult_pkg::*;
#(
   parameter int W     = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic [1:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_result,
   output logic [2*W-1:0]   out_product,
   output logic [TAG_W-1:0] out_tag
);

   localparam int H = W / 2;

   logic w_adv1, w_adv2, w_adv3;

   logic             v1_q, v1_d;
   logic [W-1:0]     a1_q, a1_d, b1_q, b1_d;
   logic [1:0]       op1_q, op1_d;
   logic [TAG_W-1:0] tag1_q, tag1_d;

   logic             v2_q, v2_d;
   logic             aneg2_q, aneg2_d, bneg2_q, bneg2_d;
   logic [W-1:0]     a2_q, a2_d, b2_q, b2_d;
   logic [1:0]       op2_q, op2_d;
   logic [TAG_W-1:0] tag2_q, tag2_d;
   logic [W-1:0]     pp [4];

   logic             v3_q, v3_d;
   logic [2*W-1:0]   prod3_q, prod3_d;
   logic [1:0]       op3_q, op3_d;
   logic [TAG_W-1:0] tag3_q, tag3_d;
   logic [2*W-1:0]   w_sum, w_prod;

   // Each stage advances when everything downstream can make room; bubbles collapse.
   assign w_adv3   = ~v3_q | out_ready;
   assign w_adv2   = w_adv3 | ~v2_q;
   assign w_adv1   = w_adv2 | ~v1_q;
   assign in_ready = w_adv1;

   always_comb begin
      v1_d   = v1_q;
      a1_d   = a1_q;
      b1_d   = b1_q;
      op1_d  = op1_q;
      tag1_d = tag1_q;
      if (w_adv1) begin
         v1_d   = in_valid;
         a1_d   = in_a;
         b1_d   = in_b;
         op1_d  = in_op;
         tag1_d = in_tag;
      end
   end

   // pp[0]=lo*lo, pp[1]=lo*hi, pp[2]=hi*lo, pp[3]=hi*hi
   for (genvar i = 0; i < 4; i++) begin : g_pp
      nios_mult_pp #(.H(H)) u_pp (
         .clk   (clk),
         .reset (reset),
         .en    (w_adv2),
         .a     (a1_q[(i/2)*H +: H]),
         .b     (b1_q[(i%2)*H +: H]),
         .p     (pp[i])
      );
   end

   always_comb begin
      v2_d    = v2_q;
      aneg2_d = aneg2_q;
      bneg2_d = bneg2_q;
      a2_d    = a2_q;
      b2_d    = b2_q;
      op2_d   = op2_q;
      tag2_d  = tag2_q;
      if (w_adv2) begin
         v2_d    = v1_q;
         aneg2_d = op_a_signed(op1_q) & a1_q[W-1];
         bneg2_d = op_b_signed(op1_q) & b1_q[W-1];
         a2_d    = a1_q;
         b2_d    = b1_q;
         op2_d   = op1_q;
         tag2_d  = tag1_q;
      end
   end

   // Signed results fall out of the unsigned product by subtracting the other operand at weight 2^W.
   always_comb begin
      w_sum  = {{W{1'b0}}, pp[0]}
             + ({{W{1'b0}}, pp[1]} << H)
             + ({{W{1'b0}}, pp[2]} << H)
             + {pp[3], {W{1'b0}}};
      w_prod = w_sum
             - (aneg2_q ? {b2_q, {W{1'b0}}} : '0)
             - (bneg2_q ? {a2_q, {W{1'b0}}} : '0);
   end

   always_comb begin
      v3_d    = v3_q;
      prod3_d = prod3_q;
      op3_d   = op3_q;
      tag3_d  = tag3_q;
      if (w_adv3) begin
         v3_d    = v2_q;
         prod3_d = w_prod;
         op3_d   = op2_q;
         tag3_d  = tag2_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1_q    <= 1'b0;
         a1_q    <= '0;
         b1_q    <= '0;
         op1_q   <= '0;
         tag1_q  <= '0;
         v2_q    <= 1'b0;
         aneg2_q <= 1'b0;
         bneg2_q <= 1'b0;
         a2_q    <= '0;
         b2_q    <= '0;
         op2_q   <= '0;
         tag2_q  <= '0;
         v3_q    <= 1'b0;
         prod3_q <= '0;
         op3_q   <= '0;
         tag3_q  <= '0;
      end else begin
         v1_q    <= v1_d;
         a1_q    <= a1_d;
         b1_q    <= b1_d;
         op1_q   <= op1_d;
         tag1_q  <= tag1_d;
         v2_q    <= v2_d;
         aneg2_q <= aneg2_d;
         bneg2_q <= bneg2_d;
         a2_q    <= a2_d;
         b2_q    <= b2_d;
         op2_q   <= op2_d;
         tag2_q  <= tag2_d;
         v3_q    <= v3_d;
         prod3_q <= prod3_d;
         op3_q   <= op3_d;
         tag3_q  <= tag3_d;
      end
   end

   assign out_valid   = v3_q;
   assign out_product = prod3_q;
   assign out_tag     = tag3_q;
   assign out_result  = op_is_high(op3_q) ? prod3_q[2*W-1:W] : prod3_q[W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_nios_mult_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_nios_mult_pipe : directed vectors, handshake corners and random |
// |                     ops against a reference product (W=32, W=8)    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_nios_mult_pipe;

   localparam int NOPS = 10000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_a, in_b, out_result;
   logic [1:0]  in_op;
   logic [4:0]  in_tag, out_tag;
   logic [63:0] out_product;

   logic        s8_in_valid, s8_in_ready, s8_out_valid, s8_out_ready;
   logic [7:0]  s8_in_a, s8_in_b, s8_out_result;
   logic [1:0]  s8_in_op;
   logic [4:0]  s8_in_tag, s8_out_tag;
   logic [15:0] s8_out_product;

   nios_mult_pipe #(.W(32), .TAG_W(5)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_product(out_product), .out_tag(out_tag)
   );

   nios_mult_pipe #(.W(8), .TAG_W(5)) dut8 (
      .clk(clk), .reset(reset),
      .in_valid(s8_in_valid), .in_ready(s8_in_ready),
      .in_a(s8_in_a), .in_b(s8_in_b), .in_op(s8_in_op), .in_tag(s8_in_tag),
      .out_valid(s8_out_valid), .out_ready(s8_out_ready),
      .out_result(s8_out_result), .out_product(s8_out_product), .out_tag(s8_out_tag)
   );

   int checks = 0;
   int errors = 0;
   int iter   = 0;
   bit chk_lat = 1'b0;

   typedef struct {
      logic [31:0] res;
      logic [63:0] prod;
      logic [4:0]  tag;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
      logic [31:0] res;
      logic [63:0] prod;
   } vec_t;

   exp_t q32[$];
   exp_t q8[$];
   vec_t tbl[15];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Reference: sign-extend operands as the op dictates, multiply wide, keep 2w bits.
   function automatic logic [127:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] op, input int w);
      logic signed [127:0] sa, sb, p;
      sa = {96'd0, a};
      sb = {96'd0, b};
      if ((op == 2'b10 || op == 2'b11) && a[w-1]) sa = sa - (128'sd1 <<< w);
      if (op == 2'b11 && b[w-1])                  sb = sb - (128'sd1 <<< w);
      p = sa * sb;
      return p & ((128'd1 << (2 * w)) - 128'd1);
   endfunction

   function automatic logic [31:0] ref_res(input logic [127:0] p, input logic [1:0] op, input int w);
      logic [127:0] r;
      r = (op == 2'b00) ? p : (p >> w);
      r = r & ((128'd1 << w) - 128'd1);
      return r[31:0];
   endfunction

   function automatic logic [31:0] rnd(input int w);
      logic [31:0] v, m;
      m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      case ($urandom_range(0, 7))
         0:       v = 32'd1 << (w - 1);
         1:       v = m;
         2:       v = 32'd0;
         3:       v = (32'd1 << (w - 1)) - 32'd1;
         default: v = $urandom;
      endcase
      return v & m;
   endfunction

   // One clock on the 32-bit DUT: drive after the edge, settle, then score both handshakes.
   task automatic cyc32(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [4:0] tag, input logic ordy, input logic [31:0] eres,
                        input logic [63:0] eprod, output logic acc);
      exp_t e;
      @(posedge clk); #1;
      in_valid  = v;
      in_a      = a;
      in_b      = b;
      in_op     = op;
      in_tag    = tag;
      out_ready = ordy;
      @(negedge clk);
      iter++;
      if (out_valid && out_ready) begin
         if (q32.size() == 0) begin
            check("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
         end else begin
            e = q32.pop_front();
            check("result", {32'd0, out_result}, {32'd0, e.res});
            check("product", out_product, e.prod);
            check("tag", {59'd0, out_tag}, {59'd0, e.tag});
            if (chk_lat) check("latency", 64'(iter - e.cyc), 64'd3);
         end
      end
      acc = in_valid && in_ready;
      if (acc) begin
         e.res  = eres;
         e.prod = eprod;
         e.tag  = tag;
         e.cyc  = iter;
         q32.push_back(e);
      end
   endtask

   task automatic drain32();
      logic acc;
      for (int k = 0; k < 20 && q32.size() != 0; k++) begin
         cyc32(1'b0, 32'd0, 32'd0, 2'b00, 5'd0, 1'b1, 32'd0, 64'd0, acc);
      end
      check("drain_empty", 64'(q32.size()), 64'd0);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin
      logic        acc;
      int          issued;
      logic [15:0] pat;
      exp_t        e;
      logic [127:0] pf;
      int          sent32, sent8, budget;

      tbl[0]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h0000_0001, 64'hFFFF_FFFE_0000_0001};
      tbl[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'hFFFF_FFFE, 64'hFFFF_FFFE_0000_0001};
      tbl[2]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001};
      tbl[3]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'h0000_0000, 64'h0000_0000_0000_0001};
      tbl[4]  = '{32'h8000_0000, 32'h8000_0000, 2'b11, 32'h4000_0000, 64'h4000_0000_0000_0000};
      tbl[5]  = '{32'h8000_0000, 32'h8000_0000, 2'b01, 32'h4000_0000, 64'h4000_0000_0000_0000};
      tbl[6]  = '{32'h8000_0000, 32'h0000_0002, 2'b11, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0000};
      tbl[7]  = '{32'h0001_0000, 32'h0001_0000, 2'b00, 32'h0000_0000, 64'h0000_0001_0000_0000};
      tbl[8]  = '{32'h0001_0000, 32'h0001_0000, 2'b01, 32'h0000_0001, 64'h0000_0001_0000_0000};
      tbl[9]  = '{32'h0000_0003, 32'hFFFF_FFFF, 2'b10, 32'h0000_0002, 64'h0000_0002_FFFF_FFFD};
      tbl[10] = '{32'h0000_0003, 32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD};
      tbl[11] = '{32'h0000_0007, 32'h0000_0006, 2'b00, 32'h0000_002A, 64'h0000_0000_0000_002A};
      tbl[12] = '{32'hFFFF_FFFE, 32'h0000_0003, 2'b10, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA};
      tbl[13] = '{32'hFFFF_FFFE, 32'h0000_0003, 2'b01, 32'h0000_0002, 64'h0000_0002_FFFF_FFFA};
      tbl[14] = '{32'hFFFF_FFFE, 32'h0000_0003, 2'b00, 32'hFFFF_FFFA, 64'h0000_0002_FFFF_FFFA};

      reset = 1'b1;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0; out_ready = 1'b0;
      s8_in_valid = 1'b0; s8_in_a = '0; s8_in_b = '0; s8_in_op = '0; s8_in_tag = '0; s8_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("reset_out_valid", {63'd0, out_valid}, 64'd0);
      check("reset_in_ready", {63'd0, in_ready}, 64'd1);
      check("reset_out_result", {32'd0, out_result}, 64'd0);
      check("reset_out_product", out_product, 64'd0);
      check("reset_out_tag", {59'd0, out_tag}, 64'd0);
      check("reset_w8_out_valid", {63'd0, s8_out_valid}, 64'd0);

      // Back-to-back table vectors, out_ready held high: fixed 3-cycle latency
      chk_lat = 1'b1;
      for (int i = 0; i < 15; i++) begin
         cyc32(1'b1, tbl[i].a, tbl[i].b, tbl[i].op, 5'(i), 1'b1, tbl[i].res, tbl[i].prod, acc);
         check("table_accept", {63'd0, acc}, 64'd1);
      end
      drain32();

      // Stall: 5 ops offered, consumer blocked for 6 cycles
      chk_lat = 1'b0;
      issued = 0;
      for (int k = 1; k <= 6; k++) begin
         cyc32(issued < 5, 32'(issued + 1), 32'd1, 2'b00, 5'(issued + 1), 1'b0,
               32'(issued + 1), 64'(issued + 1), acc);
         if (acc) issued++;
         if (k >= 4) begin
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
            check("stall_out_valid", {63'd0, out_valid}, 64'd1);
            check("stall_out_tag", {59'd0, out_tag}, 64'd1);
            check("stall_out_result", {32'd0, out_result}, 64'd1);
         end
      end
      check("stall_accepts", 64'(issued), 64'd3);
      // Full pipe with a pop: push must be accepted in the same cycle
      cyc32(issued < 5, 32'(issued + 1), 32'd1, 2'b00, 5'(issued + 1), 1'b1,
            32'(issued + 1), 64'(issued + 1), acc);
      check("full_push_pop_accept", {63'd0, acc}, 64'd1);
      if (acc) issued++;
      for (int k = 0; k < 10 && issued < 5; k++) begin
         cyc32(1'b1, 32'(issued + 1), 32'd1, 2'b00, 5'(issued + 1), 1'b1,
               32'(issued + 1), 64'(issued + 1), acc);
         if (acc) issued++;
      end
      check("stall_issued_all", 64'(issued), 64'd5);
      drain32();

      // Bubbles: out_valid mirrors in_valid three cycles later
      pat = 16'b0101_0101_1100_1101;
      for (int i = 0; i < 19; i++) begin
         cyc32((i < 16) ? pat[i] : 1'b0, 32'(i), 32'd3, 2'b00, 5'(i), 1'b1,
               32'(3 * i), 64'(3 * i), acc);
         if (i >= 3) check("bubble_out_valid", {63'd0, out_valid}, {63'd0, pat[i-3]});
      end
      drain32();

      // Reset with two ops in flight
      cyc32(1'b1, 32'd5, 32'd5, 2'b00, 5'd9, 1'b1, 32'd25, 64'd25, acc);
      cyc32(1'b1, 32'd6, 32'd6, 2'b00, 5'd10, 1'b0, 32'd36, 64'd36, acc);
      cyc32(1'b0, 32'd0, 32'd0, 2'b00, 5'd0, 1'b0, 32'd0, 64'd0, acc);
      cyc32(1'b0, 32'd0, 32'd0, 2'b00, 5'd0, 1'b0, 32'd0, 64'd0, acc);
      check("pre_reset_out_valid", {63'd0, out_valid}, 64'd1);
      q32.delete();
      reset = 1'b1;
      #1;
      check("async_reset_out_valid", {63'd0, out_valid}, 64'd0);
      check("async_reset_out_result", {32'd0, out_result}, 64'd0);
      check("async_reset_out_tag", {59'd0, out_tag}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc32(1'b0, 32'd0, 32'd0, 2'b00, 5'd0, 1'b1, 32'd0, 64'd0, acc);
         check("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
         check("post_reset_out_valid", {63'd0, out_valid}, 64'd0);
      end

      // Random ops on both widths, random backpressure
      sent32 = 0;
      sent8  = 0;
      budget = 0;
      while ((sent32 < NOPS || sent8 < NOPS || q32.size() != 0 || q8.size() != 0) && budget < 60000) begin
         budget++;
         @(posedge clk); #1;
         in_valid     = (sent32 < NOPS) && ($urandom_range(0, 3) != 0);
         in_a         = rnd(32);
         in_b         = rnd(32);
         in_op        = 2'($urandom_range(0, 3));
         in_tag       = 5'(sent32);
         out_ready    = $urandom_range(0, 3) != 0;
         s8_in_valid  = (sent8 < NOPS) && ($urandom_range(0, 3) != 0);
         s8_in_a      = 8'(rnd(8));
         s8_in_b      = 8'(rnd(8));
         s8_in_op     = 2'($urandom_range(0, 3));
         s8_in_tag    = 5'(sent8);
         s8_out_ready = $urandom_range(0, 3) != 0;
         @(negedge clk);
         if (out_valid && out_ready) begin
            if (q32.size() == 0) begin
               check("rand32_unexpected", {63'd0, out_valid}, 64'd0);
            end else begin
               e = q32.pop_front();
               check("rand32_result", {32'd0, out_result}, {32'd0, e.res});
               check("rand32_product", out_product, e.prod);
               check("rand32_tag", {59'd0, out_tag}, {59'd0, e.tag});
            end
         end
         if (in_valid && in_ready) begin
            pf     = ref_prod(in_a, in_b, in_op, 32);
            e.prod = pf[63:0];
            e.res  = ref_res(pf, in_op, 32);
            e.tag  = in_tag;
            e.cyc  = 0;
            q32.push_back(e);
            sent32++;
         end
         if (s8_out_valid && s8_out_ready) begin
            if (q8.size() == 0) begin
               check("rand8_unexpected", {63'd0, s8_out_valid}, 64'd0);
            end else begin
               e = q8.pop_front();
               check("rand8_result", {56'd0, s8_out_result}, {32'd0, e.res});
               check("rand8_product", {48'd0, s8_out_product}, e.prod);
               check("rand8_tag", {59'd0, s8_out_tag}, {59'd0, e.tag});
            end
         end
         if (s8_in_valid && s8_in_ready) begin
            pf     = ref_prod({24'd0, s8_in_a}, {24'd0, s8_in_b}, s8_in_op, 8);
            e.prod = pf[63:0];
            e.res  = ref_res(pf, s8_in_op, 8);
            e.tag  = s8_in_tag;
            e.cyc  = 0;
            q8.push_back(e);
            sent8++;
         end
      end
      check("rand32_sent", 64'(sent32), 64'(NOPS));
      check("rand8_sent", 64'(sent8), 64'(NOPS));
      check("rand32_drained", 64'(q32.size()), 64'd0);
      check("rand8_drained", 64'(q8.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/nios_mult_pipe.md
Name: nios_mult_pipe

Overview:
- Parametrised pipelined integer multiplier for the Nios II-style execute datapath.
- Successor to the fixed 16x16 three-partial-product multiplier cell. It forms the full 2W-bit product from four half-width partial products, including hi*hi.
- Adds per-operation signedness (MUL / MULXUU / MULXSU / MULXSS), valid/ready backpressure and a sideband tag, so the CPU or a custom-instruction slave can issue back-to-back operations.

Parameters:
- W, 32, operand width; must be even and >= 4. Half width H = W/2.
- TAG_W, 5, width of the sideband tag carried alongside each operation (e.g. destination register index).

Ports:
- clk  in  1  sole clock; all state is updated on its rising edge.
- reset  in  1  asynchronous, active-high reset; clears all pipeline state.
- in_valid  in  1  operation present on the in_* bus.
- in_ready  out  1  block accepts an operation this cycle.
- in_a  in  W  operand A (the src1 operand).
- in_b  in  W  operand B (the src2 operand).
- in_op  in  2  00=MUL (low word), 01=MULXUU, 10=MULXSU (A signed, B unsigned), 11=MULXSS; codes 01, 10, 11 return the high word.
- in_tag  in  TAG_W  sideband, returned unchanged with the result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_result  out  W  selected word per op.
- out_product  out  2W  full product, interpreted according to op signedness.
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Handshakes:
  - A transfer occurs when valid & ready are both high, on either side.
  - in_ready = ~v3 | out_ready | ~v2 | ~v1; this is the same as stage 1 being able to advance.
- Three stages, each holding a valid bit vN:
  - S1 registers A, B, op and tag.
  - S2 registers the four unsigned HxH partial products (ll, lh, hl, hh), the signs aneg/bneg, the A/B unsigned values needed for correction, op and tag.
  - S3 registers the summed, corrected product, op and tag.
- Advance rules:
  - S3 loads when ~v3 | out_ready.
  - S2 loads when S3 can load or ~v2.
  - S1 loads when S2 can load or ~v1.
  - A stage that loads from an empty upstream stage clears its own valid bit; bubbles collapse.
- Latency is exactly 3 cycles from input acceptance to out_valid when out_ready is held high.
- Throughput is 1 operation per clock with no stalls.
- When stalled, out_* hold stable and data registers do not change.
- Arithmetic:
  - U = ll + (lh << H) + (hl << H) + (hh << W), computed modulo 2^(2W).
  - aneg = A[W-1] when op is 10 or 11; bneg = B[W-1] when op is 11.
  - P = U - (aneg ? B<<W : 0) - (bneg ? A<<W : 0), computed modulo 2^(2W).
  - For op 00, P = U; the low word is identical for every signedness.
- Output selection:
  - out_result = P[W-1:0] for op 00, else P[2W-1:W].
  - out_product = P for every op.
- Reset:
  - All vN = 0; out_valid = 0; out_result, out_product and out_tag = 0.
  - in_ready = 1 from the first cycle after reset deasserts.
  - Reset mid-operation discards all in-flight operations without producing a result.
- Simultaneous events: while full and stalled, a push and a pop in the same cycle both succeed, and every stage shifts.
- X-safety: data registers of invalid stages may hold stale values. out_* data are meaningful only while out_valid = 1.

Decomposition:
- Shared package nios_mult_pkg:
  - op code constants OP_MUL, OP_MULXUU, OP_MULXSU, OP_MULXSS;
  - function op_is_high(op);
  - functions op_a_signed(op) and op_b_signed(op).
- One sub-module, nios_mult_pp: a registered HxH unsigned multiplier with an enable. It is instantiated four times in S2 so synthesis maps each instance to a DSP block.
- The stage-advance and valid logic stays in the top level.

Test Plan:
- A=B=0xFFFFFFFF, all four ops back-to-back, out_ready=1 -> results in order on cycles 3,4,5,6: MUL 0x00000001; MULXUU 0xFFFFFFFE; MULXSU 0xFFFFFFFF; MULXSS 0x00000000. For MULXSU, out_product = 0xFFFFFFFF00000001.
- A=B=0x80000000, MULXSS and MULXUU -> both out_result = 0x40000000; A=0x80000000, B=0x00000002, MULXSS -> 0xFFFFFFFF, product 0xFFFFFFFF00000000.
- Issue 5 ops with tags 1..5, out_ready=0 for 6 cycles:
  - in_ready drops after 3 accepts; out_valid stays 1 and out_tag stays 1 throughout the stall.
  - After out_ready rises, tags 1..5 emerge in order with no loss or duplication.
- Alternating in_valid (bubbles) with out_ready=1 -> out_valid pattern equals the in_valid pattern delayed by 3 cycles.
- Assert reset for 1 cycle with 2 ops in flight -> out_valid=0 immediately (asynchronous); no result for those ops appears; in_ready=1 on the next cycle.
- Random A, B, op for 10k ops with random out_ready, run at W=32 and at W=8 -> each result matches a reference signed/unsigned 2W-bit product and word selection.
